fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_pc_register.sv | 38 +++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// PC increment and the default reset PC.
package fetch_stage_pkg;

  // Fetch sequencing states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

  // Byte distance between consecutive instructions
  localparam int unsigned PC_INCR = 32'd4;

  // PC loaded on reset unless the instance overrides it (must be word aligned)
  localparam int unsigned RESET_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register for the fetch stage. Holds PCF, loads a redirect
// target or advances by one instruction; the incrementer lives here so the
// fetch FSM can reuse PCF+4 for the IF/ID PC+4 value.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter int             size     = 31,
  parameter logic [size:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load_en,
  input  logic [size:0]     load_val,
  input  logic              incr_en,
  output logic [size:0]     pcf,
  output logic [size:0]     pc_plus
);

  logic [size:0] pcf_r;

  // PC+4 wraps modulo 2^(size+1); no carry is kept
  assign pc_plus = pcf_r + (size+1)'(PC_INCR);
  assign pcf     = pcf_r;

  // PC register: a redirect load wins over the sequential increment
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pcf_r <= RESET_PC;
    end else if (load_en) begin
      pcf_r <= load_val;
    end else if (incr_en) begin
      pcf_r <= pc_plus;
    end else begin
      pcf_r <= pcf_r;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Issues one request at a time to a variable-latency
// instruction memory, holds the returned word and its PC+4 for IF/ID, and
// applies decode redirects. A redirect while a fetch is in flight marks that
// fetch stale so its response is thrown away when it arrives.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int             size     = 31,
  parameter logic [size:0]  RESET_PC = (size+1)'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              StallF,
  input  logic              PCSrcD,
  input  logic [size:0]     PCBranchD,
  input  logic              JumpD,
  input  logic [size:0]     PCJumpD,
  output logic              imem_req,
  output logic [size:0]     imem_addr,
  input  logic              imem_rvalid,
  input  logic [size:0]     imem_rdata,
  output logic [size:0]     RD,
  output logic [size:0]     PCPlusF,
  output logic              InstrValidF
);

  // Clears the two byte-offset bits of an address
  localparam logic [size:0] ALIGN_MASK = {{(size-1){1'b1}}, 2'b00};

  fetch_state_t  state_r;
  fetch_state_t  state_nx_s;
  logic          kill_r;
  logic          kill_nx_s;
  logic          redir_s;
  logic          consume_s;
  logic [size:0] raw_target_s;
  logic [size:0] target_s;
  logic          pc_load_s;
  logic          pc_incr_s;
  logic          capture_s;
  logic [size:0] pcf_s;
  logic [size:0] pc_plus_s;
  logic [size:0] rd_r;
  logic [size:0] pcplus_r;

  // A stalled stage neither consumes nor redirects; jump beats branch
  assign redir_s      = (JumpD | PCSrcD) & ~StallF;
  assign consume_s    = (state_r == ST_VALID) & ~StallF & ~redir_s;
  assign raw_target_s = JumpD ? PCJumpD : PCBranchD;
  assign target_s     = raw_target_s & ALIGN_MASK;

  pc_register #(
    .size     (size),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .clr_n    (clr_n),
    .load_en  (pc_load_s),
    .load_val (target_s),
    .incr_en  (pc_incr_s),
    .pcf      (pcf_s),
    .pc_plus  (pc_plus_s)
  );

  // Next-state, kill flag and PC/output-register control
  always_comb begin
    state_nx_s = state_r;
    kill_nx_s  = kill_r;
    pc_load_s  = 1'b0;
    pc_incr_s  = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nx_s = ST_REQ;
      end
      ST_REQ: begin
        state_nx_s = ST_WAIT;
        if (redir_s) begin
          pc_load_s = 1'b1;
          kill_nx_s = 1'b1;
        end else begin
          kill_nx_s = kill_r;
        end
      end
      ST_WAIT: begin
        if (!imem_rvalid) begin
          if (redir_s) begin
            pc_load_s = 1'b1;
            kill_nx_s = 1'b1;
          end else begin
            kill_nx_s = kill_r;
          end
        end else if (kill_r || redir_s) begin
          // Response belongs to a fetch that is no longer wanted
          kill_nx_s  = 1'b0;
          pc_load_s  = redir_s;
          state_nx_s = ST_REQ;
        end else begin
          capture_s  = 1'b1;
          state_nx_s = ST_VALID;
        end
      end
      ST_VALID: begin
        if (consume_s) begin
          pc_incr_s  = 1'b1;
          state_nx_s = ST_REQ;
        end else if (redir_s) begin
          pc_load_s  = 1'b1;
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_VALID;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        kill_nx_s  = 1'b0;
      end
    endcase
  end

  // FSM state and stale-fetch flag
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      kill_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      kill_r  <= kill_nx_s;
    end
  end

  // Held instruction and its PC+4; kept after consume since IF/ID has them
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_r     <= '0;
      pcplus_r <= '0;
    end else if (capture_s) begin
      rd_r     <= imem_rdata;
      pcplus_r <= pc_plus_s;
    end else begin
      rd_r     <= rd_r;
      pcplus_r <= pcplus_r;
    end
  end

  assign imem_req    = (state_r == ST_REQ);
  assign InstrValidF = (state_r == ST_VALID);
  assign imem_addr   = pcf_s & ALIGN_MASK;
  assign RD          = rd_r;
  assign PCPlusF     = pcplus_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a transaction-level reference model
// and a latency-programmable instruction memory responder.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic        JumpD = 1'b0;
  logic [31:0] PCJumpD = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] RD;
  logic [31:0] PCPlusF;
  logic        InstrValidF;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] req_addr = 32'h0;

  fetch_stage #(.size(31), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .StallF      (StallF),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .JumpD       (JumpD),
    .PCJumpD     (PCJumpD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .RD          (RD),
    .PCPlusF     (PCPlusF),
    .InstrValidF (InstrValidF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h8C09_0004;
      32'hFFFF_FFFC: return 32'h0000_0000;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Memory: answers each request lat cycles after the request cycle
  always @(negedge clk) begin
    if (!clr_n) begin
      cnt <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata <= 32'h0;
    end else begin
      if (imem_req) begin
        cnt <= lat;
        req_addr <= imem_addr;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end
      imem_rvalid <= (cnt == 1);
      imem_rdata <= (cnt == 1) ? mem_word(req_addr) : 32'h0;
    end
  end

  // Reference model: a fetch is either being issued, outstanding (possibly
  // stale), or delivered and held until decode takes it or redirects.
  bit          m_init = 1'b0;
  bit          m_boot, m_req, m_out, m_stale, m_hold;
  logic [31:0] m_pc, m_rd, m_pcplus;
  logic        m_redir;
  logic [31:0] m_tgt;
  assign m_redir = (JumpD | PCSrcD) & ~StallF;
  assign m_tgt   = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_init <= 1'b1; m_boot <= 1'b1; m_req <= 1'b0; m_out <= 1'b0;
      m_stale <= 1'b0; m_hold <= 1'b0;
      m_pc <= 32'h0; m_rd <= 32'h0; m_pcplus <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_req <= 1'b1;
    end else if (m_req) begin
      m_req <= 1'b0;
      m_out <= 1'b1;
      if (m_redir) begin m_pc <= m_tgt; m_stale <= 1'b1; end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out <= 1'b0;
        if (m_stale || m_redir) begin
          m_stale <= 1'b0;
          m_req <= 1'b1;
          if (m_redir) m_pc <= m_tgt;
        end else begin
          m_rd <= imem_rdata;
          m_pcplus <= m_pc + 32'd4;
          m_hold <= 1'b1;
        end
      end else if (m_redir) begin
        m_pc <= m_tgt;
        m_stale <= 1'b1;
      end
    end else if (m_hold && !StallF) begin
      m_hold <= 1'b0;
      m_req <= 1'b1;
      m_pc <= m_redir ? m_tgt : m_pc + 32'd4;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_req",   {31'b0, imem_req},    {31'b0, m_req});
      chk("cmp_addr",  imem_addr,            m_pc & 32'hFFFF_FFFC);
      chk("cmp_rd",    RD,                   m_rd);
      chk("cmp_pcplus", PCPlusF,             m_pcplus);
      chk("cmp_valid", {31'b0, InstrValidF}, {31'b0, m_hold});
    end
  end

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (InstrValidF) return;
      @(negedge clk);
    end
    failures++;
    $display("FAIL %s timeout waiting for InstrValidF actual=0 expected=1", name);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    failures++;
    $display("FAIL %s timeout waiting for imem_req actual=0 expected=1", name);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // 1. Reset
    repeat (3) @(negedge clk);
    chk("rst_req",    {31'b0, imem_req},    32'h0);
    chk("rst_rd",     RD,                   32'h0);
    chk("rst_pcplus", PCPlusF,              32'h0);
    chk("rst_valid",  {31'b0, InstrValidF}, 32'h0);
    chk("rst_addr",   imem_addr,            32'h0);
    #2 clr_n = 1'b1;
    @(negedge clk);
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         32'h0);

    // 2. Sequential fetch with 1-cycle memory
    wait_valid("seq0");
    chk("seq0_rd",     RD,      32'h2008_0005);
    chk("seq0_pcplus", PCPlusF, 32'h0000_0004);
    @(negedge clk);
    chk("seq1_req",  {31'b0, imem_req}, 32'h1);
    chk("seq1_addr", imem_addr,         32'h0000_0004);
    wait_valid("seq1");
    chk("seq1_rd",     RD,      32'h8C09_0004);
    chk("seq1_pcplus", PCPlusF, 32'h0000_0008);

    // 3. Stall while holding a valid instruction
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid",  {31'b0, InstrValidF}, 32'h1);
      chk("stall_rd",     RD,                   32'h8C09_0004);
      chk("stall_pcplus", PCPlusF,              32'h0000_0008);
      chk("stall_req",    {31'b0, imem_req},    32'h0);
    end
    StallF = 1'b0;
    lat = 3;
    @(negedge clk);
    chk("unstall_req",  {31'b0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr,         32'h0000_0008);

    // 4. Branch during WAIT makes the in-flight fetch stale
    @(negedge clk);
    PCSrcD = 1'b1;
    PCBranchD = 32'h0000_0040;
    @(negedge clk);
    PCSrcD = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stale_valid", {31'b0, InstrValidF}, 32'h0);
      if (imem_req) break;
    end
    chk("stale_req",  {31'b0, imem_req}, 32'h1);
    chk("stale_addr", imem_addr,         32'h0000_0040);

    // 5. Jump beats branch, target aligned
    wait_valid("prio");
    chk("prio_rd", RD, 32'hA5A5_0040);
    JumpD = 1'b1; PCJumpD = 32'h0000_0103;
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0080;
    @(negedge clk);
    JumpD = 1'b0; PCSrcD = 1'b0;
    chk("prio_valid", {31'b0, InstrValidF}, 32'h0);
    chk("prio_addr",  imem_addr,            32'h0000_0100);

    // 6. Wrap of PC+4, then reset in the middle of a fetch
    wait_valid("wrap_src");
    JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
    @(negedge clk);
    JumpD = 1'b0;
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap");
    chk("wrap_rd",     RD,      32'h0000_0000);
    chk("wrap_pcplus", PCPlusF, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_next_req",  {31'b0, imem_req}, 32'h1);
    chk("wrap_next_addr", imem_addr,         32'h0000_0000);
    wait_valid("after_wrap");
    chk("after_wrap_rd",     RD,      32'h2008_0005);
    chk("after_wrap_pcplus", PCPlusF, 32'h0000_0004);
    lat = 5;
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 32'h0000_0004);
    @(negedge clk);
    #2 clr_n = 1'b0;
    lat = 1;
    #1;
    chk("midrst_rd",     RD,                   32'h0);
    chk("midrst_pcplus", PCPlusF,              32'h0);
    chk("midrst_valid",  {31'b0, InstrValidF}, 32'h0);
    chk("midrst_req",    {31'b0, imem_req},    32'h0);
    chk("midrst_addr",   imem_addr,            32'h0);
    repeat (2) @(negedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    wait_req("post_rst");
    chk("post_rst_addr", imem_addr, 32'h0);
    wait_valid("post_rst");
    chk("post_rst_rd", RD, 32'h2008_0005);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
